washer_actuator_ctrl: RTL and testbench

Downstream stage of the washing-cycle sequencer. Consumes the 3-bit phase code and done flag, and drives the physical actuators: inlet valve, drain pump, drum motor (enable, direction, speed) and door lock. Adds agitation reversal, spin ramping, sensor timeouts and a door-safety interlock. Faults are sticky until reset.

---
 rtl/washer_pkg.sv | 47 ++++
 rtl/washer_speed_ramp.sv | 46 ++++
 rtl/washer_actuator_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_washer_actuator_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/washer_pkg.sv
// washer_pkg: shared definitions for the washer actuator stage.
//   - phase encoding (common with the upstream sequencer)
//   - actuator state enum
//   - speed / timer widths and small helper functions
package washer_pkg;

   localparam int SPEED_W = 8;
   localparam int TMR_W   = 12;

   localparam logic [2:0] PH_IDLE  = 3'd0;
   localparam logic [2:0] PH_FILL  = 3'd1;
   localparam logic [2:0] PH_WASH  = 3'd2;
   localparam logic [2:0] PH_RINSE = 3'd3;
   localparam logic [2:0] PH_DRAIN = 3'd4;
   localparam logic [2:0] PH_SPIN  = 3'd5;
   localparam logic [2:0] PH_OVER  = 3'd6;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FILL,
      ST_FILL_HOLD,
      ST_AGI_FWD,
      ST_AGI_PAUSE,
      ST_AGI_REV,
      ST_DRAIN,
      ST_SPIN,
      ST_COAST,
      ST_FAULT
   } act_state_t;

   // State a phase code asks for when entered from rest; 7 falls into idle.
   function automatic act_state_t phase_state(input logic [2:0] ph);
      case (ph)
         PH_FILL:           return ST_FILL;
         PH_WASH, PH_RINSE: return ST_AGI_FWD;
         PH_DRAIN:          return ST_DRAIN;
         PH_SPIN:           return ST_SPIN;
         PH_IDLE, PH_OVER:  return ST_IDLE;
         default:           return ST_IDLE;
      endcase
   endfunction

   function automatic logic [TMR_W-1:0] tmr_inc(input logic [TMR_W-1:0] t);
      return (&t) ? t : t + 1'b1;
   endfunction

endpackage

// File: rtl/washer_speed_ramp.sv
// washer_speed_ramp: registered motor speed that moves toward a target by at
// most one step per enabled cycle, landing exactly on the target (no overshoot,
// no wrap). A step of full scale makes the speed jump straight to the target.
// Ports:
//   clk, rst      clock, synchronous active-high reset (speed -> 0)
//   i_en          update enable
//   i_target      speed to approach
//   i_step        maximum change per cycle
//   o_speed       registered speed
module washer_speed_ramp
   import washer_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_en,
   input  logic [SPEED_W-1:0] i_target,
   input  logic [SPEED_W-1:0] i_step,
   output logic [SPEED_W-1:0] o_speed
);

   logic [SPEED_W-1:0] r_speed;
   logic [SPEED_W-1:0] w_speed_nxt;
   logic [SPEED_W-1:0] w_gap;

   // The gap compare guarantees r_speed +/- i_step stays strictly inside
   // [0, 255], so neither direction can wrap.
   always_comb begin
      w_speed_nxt = r_speed;
      w_gap       = '0;
      if (r_speed < i_target) begin
         w_gap       = i_target - r_speed;
         w_speed_nxt = (w_gap > i_step) ? r_speed + i_step : i_target;
      end else if (r_speed > i_target) begin
         w_gap       = r_speed - i_target;
         w_speed_nxt = (w_gap > i_step) ? r_speed - i_step : i_target;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)       r_speed <= '0;
      else if (i_en) r_speed <= w_speed_nxt;
   end

   assign o_speed = r_speed;

endmodule

// File: rtl/washer_actuator_ctrl.sv
// washer_actuator_ctrl: turns the sequencer's phase code into actuator drive
// (valve, pump, motor, door lock) with agitation reversal, spin ramping,
// sensor timeouts and a sticky door/timeout fault.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   i_phase[2:0]          sequencer phase code
//   i_done                sequencer cycle-complete flag
//   i_water_full/empty    level sensors
//   i_door_closed         door switch
//   o_inlet_valve, o_drain_pump, o_motor_en, o_motor_dir,
//   o_motor_speed[7:0], o_door_lock, o_fault   registered actuator outputs
// Build option: WASHER_SPIN_RAMP_EN selects ramped spin-up/coast-down;
// without it the motor speed jumps directly between 0 and the spin speed.
//
// state        | meaning
// -------------+---------------------------------------------------
// ST_IDLE      | everything off, door unlocked
// ST_FILL      | inlet valve open, fill timer running
// ST_FILL_HOLD | water full, valve closed, waiting for next phase
// ST_AGI_FWD   | agitation, motor forward at wash speed
// ST_AGI_PAUSE | agitation rest between direction changes
// ST_AGI_REV   | agitation, motor reverse at wash speed
// ST_DRAIN     | pump on, drain timer runs until water empty
// ST_SPIN      | pump on, motor ramps to spin speed
// ST_COAST     | motor off, speed decays, door held until unlock delay
// ST_FAULT     | sticky fault, everything off, lock released after delay
module washer_actuator_ctrl
   import washer_pkg::*;
#(
   parameter logic [TMR_W-1:0]   AGITATE_ON    = 12'd8,
   parameter logic [TMR_W-1:0]   AGITATE_PAUSE = 12'd3,
   parameter logic [SPEED_W-1:0] WASH_SPEED    = 8'd60,
   parameter logic [SPEED_W-1:0] SPIN_SPEED    = 8'd250,
   parameter logic [SPEED_W-1:0] RAMP_STEP     = 8'd10,
   parameter logic [TMR_W-1:0]   FILL_TIMEOUT  = 12'd150,
   parameter logic [TMR_W-1:0]   DRAIN_TIMEOUT = 12'd300,
   parameter logic [3:0]         UNLOCK_DELAY  = 4'd5
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [2:0]         i_phase,
   input  logic               i_done,
   input  logic               i_water_full,
   input  logic               i_water_empty,
   input  logic               i_door_closed,
   output logic               o_inlet_valve,
   output logic               o_drain_pump,
   output logic               o_motor_en,
   output logic               o_motor_dir,
   output logic [SPEED_W-1:0] o_motor_speed,
   output logic               o_door_lock,
   output logic               o_fault
);

`ifdef WASHER_SPIN_RAMP_EN
   localparam logic [SPEED_W-1:0] MOTOR_STEP = RAMP_STEP;
`else
   // A full-scale step makes the ramp land on its target in one update.
   localparam logic [SPEED_W-1:0] MOTOR_STEP = 8'hFF | RAMP_STEP;
`endif
   localparam logic [TMR_W-1:0] ULK_LIM = TMR_W'(UNLOCK_DELAY);

   act_state_t         r_state, w_state_nxt, w_ph_state;
   logic [TMR_W-1:0]   r_tmr, w_tmr_nxt, w_tmr_inc;
   logic               r_rev_nxt;
   logic               w_agi_ph, w_door_trip;
   logic [SPEED_W-1:0] w_speed, w_tgt, w_step;
   logic               w_valve, w_pump, w_en, w_dir, w_lock, w_fault;
   logic               r_valve, r_pump, r_en, r_dir, r_lock, r_fault;
   logic               w_unused;

   // The lock follows the coast/fault timer, never the sequencer's done flag.
   assign w_unused = i_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_tmr     <= '0;
         r_rev_nxt <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tmr   <= w_tmr_nxt;
         if (w_state_nxt == ST_AGI_FWD)      r_rev_nxt <= 1'b1;
         else if (w_state_nxt == ST_AGI_REV) r_rev_nxt <= 1'b0;
      end
   end

   always_comb begin
      w_tmr_inc   = tmr_inc(r_tmr);
      w_ph_state  = phase_state(i_phase);
      w_agi_ph    = (i_phase == PH_WASH) || (i_phase == PH_RINSE);
      w_door_trip = !i_door_closed && (r_state != ST_IDLE) &&
                    (r_state != ST_COAST) && (r_state != ST_FAULT);
      w_state_nxt = r_state;
      if (w_door_trip) begin
         w_state_nxt = ST_FAULT;
      end else begin
         case (r_state)
            ST_IDLE: w_state_nxt = w_ph_state;
            ST_FILL: begin
               if (!i_water_full && r_tmr >= FILL_TIMEOUT - 12'd1) w_state_nxt = ST_FAULT;
               else if (i_phase != PH_FILL)                         w_state_nxt = w_ph_state;
               else if (i_water_full)                               w_state_nxt = ST_FILL_HOLD;
            end
            ST_FILL_HOLD: if (i_phase != PH_FILL) w_state_nxt = w_ph_state;
            ST_AGI_FWD, ST_AGI_PAUSE, ST_AGI_REV: begin
               if (i_phase == PH_SPIN) w_state_nxt = ST_SPIN;
               else if (!w_agi_ph)     w_state_nxt = ST_COAST;
               else if (r_state == ST_AGI_PAUSE) begin
                  if (r_tmr >= AGITATE_PAUSE - 12'd1)
                     w_state_nxt = r_rev_nxt ? ST_AGI_REV : ST_AGI_FWD;
               end else if (r_tmr >= AGITATE_ON - 12'd1) begin
                  w_state_nxt = ST_AGI_PAUSE;
               end
            end
            ST_DRAIN: begin
               if (!i_water_empty && r_tmr >= DRAIN_TIMEOUT - 12'd1) w_state_nxt = ST_FAULT;
               else if (i_phase != PH_DRAIN)                          w_state_nxt = w_ph_state;
            end
            ST_SPIN: begin
               if (w_agi_ph)                 w_state_nxt = ST_AGI_FWD;
               else if (i_phase != PH_SPIN)  w_state_nxt = ST_COAST;
            end
            ST_COAST: if (w_speed == '0 && w_tmr_inc >= ULK_LIM) w_state_nxt = w_ph_state;
            ST_FAULT: w_state_nxt = ST_FAULT;
            default:  w_state_nxt = ST_IDLE;
         endcase
      end

      // One shared timer; it restarts on every state change. In coast and
      // fault it only counts once the motor has stopped.
      w_tmr_nxt = '0;
      if (w_state_nxt == r_state) begin
         case (r_state)
            ST_FILL, ST_AGI_FWD, ST_AGI_PAUSE, ST_AGI_REV: w_tmr_nxt = w_tmr_inc;
            ST_DRAIN:           w_tmr_nxt = i_water_empty ? r_tmr : w_tmr_inc;
            ST_COAST, ST_FAULT: w_tmr_nxt = (w_speed == '0) ? w_tmr_inc : '0;
            default:            w_tmr_nxt = '0;
         endcase
      end
   end

   // Outputs are decoded from the next state and registered, so they change
   // on the same edge as the state.
   always_comb begin
      w_valve = 1'b0;
      w_pump  = 1'b0;
      w_en    = 1'b0;
      w_dir   = 1'b0;
      w_lock  = 1'b1;
      w_fault = 1'b0;
      w_tgt   = '0;
      w_step  = MOTOR_STEP;
      case (w_state_nxt)
         ST_IDLE:      w_lock  = 1'b0;
         ST_FILL:      w_valve = 1'b1;
         ST_AGI_FWD:   begin w_en = 1'b1; w_tgt = WASH_SPEED; w_step = 8'hFF; end
         ST_AGI_PAUSE: w_step  = 8'hFF;
         ST_AGI_REV:   begin w_en = 1'b1; w_dir = 1'b1; w_tgt = WASH_SPEED; w_step = 8'hFF; end
         ST_DRAIN:     w_pump  = 1'b1;
         ST_SPIN:      begin w_pump = 1'b1; w_en = 1'b1; w_tgt = SPIN_SPEED; end
         ST_FAULT:     begin w_fault = 1'b1; w_lock = (w_tmr_nxt < ULK_LIM); end
         default:      w_lock  = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         {r_valve, r_pump, r_en, r_dir, r_lock, r_fault} <= '0;
      end else begin
         r_valve <= w_valve;
         r_pump  <= w_pump;
         r_en    <= w_en;
         r_dir   <= w_dir;
         r_lock  <= w_lock;
         r_fault <= w_fault;
      end
   end

   washer_speed_ramp u_ramp (
      .clk      (clk),
      .rst      (rst),
      .i_en     (w_state_nxt != ST_IDLE),
      .i_target (w_tgt),
      .i_step   (w_step),
      .o_speed  (w_speed)
   );

   assign o_inlet_valve = r_valve;
   assign o_drain_pump  = r_pump;
   assign o_motor_en    = r_en;
   assign o_motor_dir   = r_dir;
   assign o_motor_speed = w_speed;
   assign o_door_lock   = r_lock;
   assign o_fault       = r_fault;

endmodule

// File: tb/tb_washer_actuator_ctrl.sv
// tb_washer_actuator_ctrl: scoreboard bench for washer_actuator_ctrl.
// Each cycle's expected output vector is queued as the stimulus is applied
// and compared after the next clock edge.
module tb_washer_actuator_ctrl;

`ifdef WASHER_SPIN_RAMP_EN
   localparam bit RAMP = 1'b1;
`else
   localparam bit RAMP = 1'b0;
`endif

   // packed outputs: {valve, pump, en, dir, speed[7:0], lock, fault}
   localparam logic [13:0] M_ALL   = 14'h3FFF;
   localparam logic [13:0] M_NODIR = 14'h3BFF;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] phase;
   logic       done, water_full, water_empty, door_closed;
   logic       inlet_valve, drain_pump, motor_en, motor_dir, door_lock, fault;
   logic [7:0] motor_speed;

   int n_checks = 0;
   int n_fail   = 0;

   logic [13:0] q_exp[$];
   logic [13:0] q_msk[$];
   string       q_tag[$];

   washer_actuator_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .i_phase       (phase),
      .i_done        (done),
      .i_water_full  (water_full),
      .i_water_empty (water_empty),
      .i_door_closed (door_closed),
      .o_inlet_valve (inlet_valve),
      .o_drain_pump  (drain_pump),
      .o_motor_en    (motor_en),
      .o_motor_dir   (motor_dir),
      .o_motor_speed (motor_speed),
      .o_door_lock   (door_lock),
      .o_fault       (fault)
   );

   always #5 clk = ~clk;

   function automatic logic [13:0] pk(input bit v, input bit p, input bit e, input bit d,
                                      input logic [7:0] s, input bit l, input bit f);
      return {v, p, e, d, s, l, f};
   endfunction

   function automatic logic [7:0] sp_up(input logic [7:0] s);
      if (!RAMP) return 8'd250;
      return (8'd250 - s > 8'd10) ? s + 8'd10 : 8'd250;
   endfunction

   function automatic logic [7:0] sp_dn(input logic [7:0] s);
      if (!RAMP) return 8'd0;
      return (s > 8'd10) ? s - 8'd10 : 8'd0;
   endfunction

   task automatic check_eq(input string tag, input logic [13:0] obs, input logic [13:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic cyc(input string tag, input logic r, input logic [2:0] ph,
                      input logic [13:0] exp, input logic [13:0] msk);
      logic [13:0] e, m, obs;
      string       t;
      rst   = r;
      phase = ph;
      q_exp.push_back(exp);
      q_msk.push_back(msk);
      q_tag.push_back(tag);
      @(posedge clk);
      #1;
      obs = {inlet_valve, drain_pump, motor_en, motor_dir, motor_speed, door_lock, fault};
      e = q_exp.pop_front();
      m = q_msk.pop_front();
      t = q_tag.pop_front();
      check_eq(t, obs & m, e & m);
   endtask

   // Motor decays from s0 with the door held; the caller checks the unlock cycle.
   task automatic coast_out(input string tag, input logic [2:0] ph,
                            input logic [7:0] s0, input bit flt);
      logic [7:0] sp;
      sp = s0;
      do begin
         sp = sp_dn(sp);
         cyc(tag, 1'b0, ph, pk(0, 0, 0, 0, sp, 1, flt), M_NODIR);
      end while (sp != 8'd0);
      repeat (4) cyc(tag, 1'b0, ph, pk(0, 0, 0, 0, 8'd0, 1, flt), M_NODIR);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  sp;
      logic [13:0] exp, msk;
      int          pos;

      rst = 1'b1; phase = 3'd0; done = 1'b0;
      water_full = 1'b0; water_empty = 1'b0; door_closed = 1'b1;

      cyc("reset", 1'b1, 3'd0, 14'h0, M_ALL);
      cyc("reset", 1'b1, 3'd0, 14'h0, M_ALL);
      cyc("idle", 1'b0, 3'd0, 14'h0, M_ALL);
      cyc("idle_ph7", 1'b0, 3'd7, 14'h0, M_ALL);
      door_closed = 1'b0;
      cyc("door_open_idle", 1'b0, 3'd0, 14'h0, M_ALL);
      door_closed = 1'b1;

      // fill, sensor after 20 cycles
      repeat (20) cyc("fill", 1'b0, 3'd1, pk(1, 0, 0, 0, 8'd0, 1, 0), M_ALL);
      water_full = 1'b1;
      repeat (3) cyc("fill_hold", 1'b0, 3'd1, pk(0, 0, 0, 0, 8'd0, 1, 0), M_ALL);
      cyc("fill_to_idle", 1'b0, 3'd0, 14'h0, M_ALL);
      water_full = 1'b0;

      // agitation: wash then rinse continues the pattern
      for (int i = 0; i < 41; i++) begin
         pos = i % 22;
         if (pos < 8) begin
            exp = pk(0, 0, 1, 0, 8'd60, 1, 0); msk = M_ALL;
         end else if (pos >= 11 && pos < 19) begin
            exp = pk(0, 0, 1, 1, 8'd60, 1, 0); msk = M_ALL;
         end else begin
            exp = pk(0, 0, 0, 0, 8'd0, 1, 0); msk = M_NODIR;
         end
         cyc("agitate", 1'b0, (i < 30) ? 3'd2 : 3'd3, exp, msk);
      end
      coast_out("wash_coast", 3'd0, 8'd60, 1'b0);
      cyc("wash_unlock", 1'b0, 3'd0, 14'h0, M_ALL);

      // spin up, then over with done: lock held through coast
      sp = 8'd0;
      for (int i = 0; i < 40; i++) begin
         sp = sp_up(sp);
         cyc("spin", 1'b0, 3'd5, pk(0, 1, 1, 0, sp, 1, 0), M_ALL);
      end
      done = 1'b1;
      coast_out("spin_coast", 3'd6, sp, 1'b0);
      cyc("spin_unlock", 1'b0, 3'd6, 14'h0, M_ALL);
      cyc("over_idle", 1'b0, 3'd6, 14'h0, M_ALL);
      done = 1'b0;

      // drain with sensor
      repeat (10) cyc("drain", 1'b0, 3'd4, pk(0, 1, 0, 0, 8'd0, 1, 0), M_ALL);
      water_empty = 1'b1;
      repeat (5) cyc("drain_empty", 1'b0, 3'd4, pk(0, 1, 0, 0, 8'd0, 1, 0), M_ALL);
      cyc("drain_to_idle", 1'b0, 3'd0, 14'h0, M_ALL);
      water_empty = 1'b0;

      // fill timeout
      repeat (150) cyc("fill_run", 1'b0, 3'd1, pk(1, 0, 0, 0, 8'd0, 1, 0), M_ALL);
      repeat (5) cyc("fill_fault", 1'b0, 3'd1, pk(0, 0, 0, 0, 8'd0, 1, 1), M_ALL);
      cyc("fill_fault_unlock", 1'b0, 3'd1, pk(0, 0, 0, 0, 8'd0, 0, 1), M_ALL);
      repeat (3) cyc("fault_sticky", 1'b0, 3'd2, pk(0, 0, 0, 0, 8'd0, 0, 1), M_ALL);
      cyc("reset", 1'b1, 3'd0, 14'h0, M_ALL);

      // door opens during forward agitation
      repeat (3) cyc("wash_door", 1'b0, 3'd2, pk(0, 0, 1, 0, 8'd60, 1, 0), M_ALL);
      door_closed = 1'b0;
      coast_out("door_fault", 3'd2, 8'd60, 1'b1);
      cyc("door_fault_unlock", 1'b0, 3'd2, pk(0, 0, 0, 0, 8'd0, 0, 1), M_ALL);
      cyc("door_sticky", 1'b0, 3'd5, pk(0, 0, 0, 0, 8'd0, 0, 1), M_ALL);
      door_closed = 1'b1;
      cyc("door_sticky", 1'b0, 3'd1, pk(0, 0, 0, 0, 8'd0, 0, 1), M_ALL);
      cyc("reset", 1'b1, 3'd0, 14'h0, M_ALL);

      // reset while spinning (speed 150 with ramping)
      sp = 8'd0;
      for (int i = 0; i < 15; i++) begin
         sp = sp_up(sp);
         cyc("spin15", 1'b0, 3'd5, pk(0, 1, 1, 0, sp, 1, 0), M_ALL);
      end
      cyc("reset_spin", 1'b1, 3'd5, 14'h0, M_ALL);
      cyc("post_reset", 1'b0, 3'd0, 14'h0, M_ALL);

      // drain timeout
      repeat (300) cyc("drain_run", 1'b0, 3'd4, pk(0, 1, 0, 0, 8'd0, 1, 0), M_ALL);
      cyc("drain_fault", 1'b0, 3'd4, pk(0, 0, 0, 0, 8'd0, 1, 1), M_ALL);
      cyc("reset", 1'b1, 3'd0, 14'h0, M_ALL);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
